cache_ctx_select_ctrl: RTL and testbench
========================================

Name: cache_ctx_select_ctrl

Overview:
- Context-switch controller sitting directly upstream of the 12-input, 32-bit cache-output multiplexer; drives that mux's 5-bit select.
- On an OS context switch, it drains outstanding cache traffic and maps the incoming process ID to a physical cache slot.
- On a miss it allocates a slot round-robin and has that slot flushed.
- It stalls the CPU for the whole switch and commits the new select atomically.

Parameters:
- NUM_SLOTS, 9, number of physical cache slots; select values 0..NUM_SLOTS-1 are legal.
- SEL_W, 5, width of cache_select.
- PID_W, 8, process ID width.
- DEFAULT_SEL, 6, select value driven after reset (slot 6).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ctx_req  in  1  context-switch request; level, held high until ctx_ack seen.
- ctx_pid  in  PID_W  new process ID; stable while ctx_req high.
- ctx_ack  out  1  four-phase acknowledge.
- cache_busy  in  1  the currently selected cache has an outstanding transaction.
- flush_req  out  1  flush/invalidate request for slot flush_idx.
- flush_idx  out  SEL_W  slot being flushed.
- flush_done  in  1  single-cycle pulse; flush complete.
- cpu_stall  out  1  CPU pipeline stall.
- cache_select  out  SEL_W  registered select to the mux.
- cur_pid  out  PID_W  PID currently owning cache_select.

Behaviour:
- Reset (synchronous, reset high at clock edge):
  - cache_select=DEFAULT_SEL; cur_pid=0.
  - ctx_ack=0, flush_req=0, flush_idx=0, cpu_stall=0.
  - All NUM_SLOTS table entries invalid; rr_ptr=0; state=IDLE.
  - Reset mid-operation aborts any state, including FLUSH (flush_req drops next edge).
- Table: NUM_SLOTS entries {valid, pid}; entry index == slot index.
- FSM: IDLE, DRAIN, LOOKUP, FLUSH, COMMIT, ACK.
- IDLE: on ctx_req=1, latch ctx_pid into req_pid, set cpu_stall=1 -> DRAIN.
- DRAIN: stay while cache_busy=1; when cache_busy=0 -> LOOKUP. Minimum one cycle.
- LOOKUP (1 cycle):
  - Hit (valid entry with pid==req_pid): hit_idx = lowest matching index -> COMMIT.
  - Miss: victim = rr_ptr; write entry[victim]={1,req_pid}; flush_idx=victim; flush_req=1; rr_ptr=(rr_ptr==NUM_SLOTS-1)?0:rr_ptr+1 -> FLUSH.
- FLUSH: flush_req held high until flush_done=1; that edge drops flush_req -> COMMIT. A flush_done pulse in any other state is ignored.
- COMMIT (1 cycle): cache_select=chosen idx; cur_pid=req_pid; ctx_ack=1 -> ACK.
- ACK: ctx_ack and cpu_stall held high while ctx_req=1; on ctx_req=0 both clear -> IDLE.
- Latency:
  - Hit with cache_busy=0: ctx_req edge -> ctx_ack high after 4 edges (IDLE->DRAIN->LOOKUP->COMMIT->ACK).
  - Miss: 4 edges + flush cycles.
- Switch to req_pid==cur_pid takes the normal hit path; cache_select is unchanged in value.
- cache_select changes only in COMMIT, i.e. only while cpu_stall=1.
- ctx_pid changes while ctx_req is high are ignored (req_pid latched).
- rr_ptr wraps from NUM_SLOTS-1 to 0.
- Out-of-range selects (>= NUM_SLOTS) are never generated.

Optional Feature:
- Macro: CTX_SWITCH_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments in LOOKUP on hit or miss respectively, saturating at 16'hFFFF.
  - Both clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles -> cache_select=6, ctx_ack=0, cpu_stall=0, flush_req=0, cur_pid=0.
- First switch, ctx_pid=8'h21, cache_busy=0: flush_req=1 with flush_idx=0; flush_done after 3 cycles -> cache_select=0, cur_pid=8'h21, ctx_ack=1; drop ctx_req -> ctx_ack=0, cpu_stall=0 next edge.
- Hit path: after 8'h21 is in slot 0 and 8'h22 in slot 1, switch to 8'h21 -> no flush_req; cache_select=0; ctx_ack 4 edges after request.
- Drain: cache_busy=1 for 5 cycles during request -> FSM stays in DRAIN, cpu_stall=1 throughout, cache_select unchanged until busy drops.
- Wrap: 10 distinct PIDs 8'h01..8'h0A with NUM_SLOTS=9 -> flush_idx sequence 0..8 then 0; entry 0 now holds 8'h0A, and a later switch to 8'h01 misses (flush_idx=1).
- Reset mid-FLUSH: assert reset while flush_req=1 -> next edge flush_req=0, cache_select=6, table invalid; a later switch to 8'h21 misses with flush_idx=0.

Source files
------------

// File: rtl/cache_ctx_select_ctrl.sv
// rtl/cache_ctx_select_ctrl.sv - context-switch controller driving the 12:1 cache-output mux select
//
// Purpose:
//   Sits directly upstream of the 32-bit cache-output multiplexer and owns its select.
//   On an OS context switch it does the following, all while holding the CPU stalled:
//     - drains outstanding cache traffic;
//     - maps the incoming process ID to a physical cache slot (PID table lookup);
//     - on a miss, allocates a slot round-robin and flushes it;
//     - commits the new select atomically.
//
// Ports:
//   clock         in   1      system clock, rising edge
//   reset         in   1      synchronous active-high reset
//   ctx_req       in   1      context-switch request (level, held until ctx_ack)
//   ctx_pid       in   PID_W  incoming process ID (latched on request)
//   ctx_ack       out  1      four-phase acknowledge
//   cache_busy    in   1      selected cache has an outstanding transaction
//   flush_req     out  1      flush/invalidate request for slot flush_idx
//   flush_idx     out  SEL_W  slot being flushed
//   flush_done    in   1      single-cycle flush-complete pulse
//   cpu_stall     out  1      CPU pipeline stall
//   cache_select  out  SEL_W  registered mux select
//   cur_pid       out  PID_W  PID currently owning cache_select
//   hit_count     out  16     saturating lookup-hit counter  (CTX_SWITCH_STATS_EN only)
//   miss_count    out  16     saturating lookup-miss counter (CTX_SWITCH_STATS_EN only)
//
// Optional feature macro: CTX_SWITCH_STATS_EN

module cache_ctx_select_ctrl #(
   parameter int NUM_SLOTS   = 9,
   parameter int SEL_W       = 5,
   parameter int PID_W       = 8,
   parameter int DEFAULT_SEL = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctx_req,
   input  logic [PID_W-1:0] ctx_pid,
   output logic             ctx_ack,
   input  logic             cache_busy,
   output logic             flush_req,
   output logic [SEL_W-1:0] flush_idx,
   input  logic             flush_done,
   output logic             cpu_stall,
   output logic [SEL_W-1:0] cache_select,
   output logic [PID_W-1:0] cur_pid
`ifdef CTX_SWITCH_STATS_EN
   ,
   output logic [15:0]      hit_count,
   output logic [15:0]      miss_count
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      LOOKUP = 3'd2,
      FLUSH  = 3'd3,
      COMMIT = 3'd4,
      ACK    = 3'd5
   } state_t;

   state_t state;
   state_t state_nxt;

   // PID-to-slot table; entry index is the physical slot index
   logic [NUM_SLOTS-1:0] tbl_valid;
   logic [PID_W-1:0]     tbl_pid [NUM_SLOTS];

   logic [PID_W-1:0]     req_pid;
   logic [SEL_W-1:0]     sel_idx;   // slot chosen in LOOKUP, applied in COMMIT
   logic [SEL_W-1:0]     rr_ptr;

   logic                 hit;
   logic [SEL_W-1:0]     hit_idx;

   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);

   // Lookup: scan from the top down so the lowest matching index wins
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (tbl_valid[i] && (tbl_pid[i] == req_pid)) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ctx_req)     state_nxt = DRAIN;
         DRAIN:   if (!cache_busy) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = hit ? COMMIT : FLUSH;
         FLUSH:   if (flush_done)  state_nxt = COMMIT;
         COMMIT:  state_nxt = ACK;
         ACK:     if (!ctx_req)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes of the registered state, so they
   // change exactly on the edges that enter/leave the corresponding states.
   always_comb begin
      cpu_stall = (state != IDLE);
      flush_req = (state == FLUSH);
      ctx_ack   = (state == ACK);
   end

   // Datapath: request latch, table, round-robin pointer, committed select
   always_ff @(posedge clock) begin
      if (reset) begin
         req_pid      <= '0;
         sel_idx      <= '0;
         rr_ptr       <= '0;
         flush_idx    <= '0;
         tbl_valid    <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            tbl_pid[i] <= '0;
         end
         cache_select <= SEL_W'(DEFAULT_SEL);
         cur_pid      <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Latch once; later ctx_pid wiggles during the switch are ignored
               if (ctx_req) begin
                  req_pid <= ctx_pid;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  sel_idx <= hit_idx;
               end else begin
                  tbl_valid[rr_ptr] <= 1'b1;
                  tbl_pid[rr_ptr]   <= req_pid;
                  flush_idx         <= rr_ptr;
                  sel_idx           <= rr_ptr;
                  rr_ptr            <= (rr_ptr == LAST_SLOT) ? '0 : rr_ptr + 1'b1;
               end
            end
            COMMIT: begin
               // Only point where the mux select moves; CPU is stalled here
               cache_select <= sel_idx;
               cur_pid      <= req_pid;
            end
            default: ;
         endcase
      end
   end

`ifdef CTX_SWITCH_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == LOOKUP) begin
         if (hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
         end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctx_select_ctrl.sv
// tb/tb_cache_ctx_select_ctrl.sv - directed self-checking bench for cache_ctx_select_ctrl

module tb_cache_ctx_select_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       ctx_req;
   logic [7:0] ctx_pid;
   logic       ctx_ack;
   logic       cache_busy;
   logic       flush_req;
   logic [4:0] flush_idx;
   logic       flush_done;
   logic       cpu_stall;
   logic [4:0] cache_select;
   logic [7:0] cur_pid;
`ifdef CTX_SWITCH_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   logic [4:0] model_sel;
   logic [7:0] model_pid;

   always #5 clock = ~clock;

   cache_ctx_select_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .ctx_req      (ctx_req),
      .ctx_pid      (ctx_pid),
      .ctx_ack      (ctx_ack),
      .cache_busy   (cache_busy),
      .flush_req    (flush_req),
      .flush_idx    (flush_idx),
      .flush_done   (flush_done),
      .cpu_stall    (cpu_stall),
      .cache_select (cache_select),
      .cur_pid      (cur_pid)
`ifdef CTX_SWITCH_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Miss path: expect a flush of exp_idx, hold flush_done off for flush_wait cycles
   task automatic switch_miss(input logic [7:0] pid, input logic [4:0] exp_idx, input int flush_wait);
      ctx_pid = pid;
      ctx_req = 1'b1;
      tick();                                   // -> DRAIN
      check("miss_stall_drain", {31'd0, cpu_stall}, 32'd1);
      tick();                                   // -> LOOKUP
      tick();                                   // -> FLUSH
      check("miss_flush_req", {31'd0, flush_req}, 32'd1);
      check("miss_flush_idx", {27'd0, flush_idx}, {27'd0, exp_idx});
      for (int k = 0; k < flush_wait; k++) begin
         tick();
         check("miss_flush_hold", {31'd0, flush_req}, 32'd1);
      end
      check("miss_sel_pre", {27'd0, cache_select}, {27'd0, model_sel});
      flush_done = 1'b1;
      tick();                                   // -> COMMIT
      flush_done = 1'b0;
      check("miss_flush_drop", {31'd0, flush_req}, 32'd0);
      check("miss_ack_early", {31'd0, ctx_ack}, 32'd0);
      tick();                                   // -> ACK
      check("miss_ack", {31'd0, ctx_ack}, 32'd1);
      check("miss_sel", {27'd0, cache_select}, {27'd0, exp_idx});
      check("miss_pid", {24'd0, cur_pid}, {24'd0, pid});
      model_sel = exp_idx;
      model_pid = pid;
      ctx_req = 1'b0;
      tick();                                   // -> IDLE
      check("miss_ack_clr", {31'd0, ctx_ack}, 32'd0);
      check("miss_stall_clr", {31'd0, cpu_stall}, 32'd0);
   endtask

   // Hit path: ctx_ack exactly 4 edges after request, no flush
   task automatic switch_hit(input logic [7:0] pid, input logic [4:0] exp_idx);
      ctx_pid = pid;
      ctx_req = 1'b1;
      tick();
      tick();
      tick();                                   // -> COMMIT
      check("hit_no_flush", {31'd0, flush_req}, 32'd0);
      check("hit_ack_early", {31'd0, ctx_ack}, 32'd0);
      check("hit_sel_pre", {27'd0, cache_select}, {27'd0, model_sel});
      tick();                                   // -> ACK
      check("hit_ack", {31'd0, ctx_ack}, 32'd1);
      check("hit_sel", {27'd0, cache_select}, {27'd0, exp_idx});
      check("hit_pid", {24'd0, cur_pid}, {24'd0, pid});
      model_sel = exp_idx;
      model_pid = pid;
      ctx_req = 1'b0;
      tick();
      check("hit_ack_clr", {31'd0, ctx_ack}, 32'd0);
      check("hit_stall_clr", {31'd0, cpu_stall}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_sel = 5'd6;
      model_pid = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      ctx_req    = 1'b0;
      ctx_pid    = 8'h00;
      cache_busy = 1'b0;
      flush_done = 1'b0;
      do_reset();

      // Reset state
      check("rst_sel", {27'd0, cache_select}, 32'd6);
      check("rst_ack", {31'd0, ctx_ack}, 32'd0);
      check("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check("rst_flush", {31'd0, flush_req}, 32'd0);
      check("rst_flush_idx", {27'd0, flush_idx}, 32'd0);
      check("rst_pid", {24'd0, cur_pid}, 32'd0);

      // First switch misses into slot 0, flush takes 3 cycles
      switch_miss(8'h21, 5'd0, 3);
      switch_miss(8'h22, 5'd1, 1);

      // Hit on 8'h21 in slot 0
      switch_hit(8'h21, 5'd0);

      // Drain: busy for 5 cycles, ctx_pid changes mid-request must be ignored
      cache_busy = 1'b1;
      ctx_pid    = 8'h22;
      ctx_req    = 1'b1;
      tick();                                   // -> DRAIN
      ctx_pid = 8'h99;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("drain_stall", {31'd0, cpu_stall}, 32'd1);
         check("drain_ack", {31'd0, ctx_ack}, 32'd0);
         check("drain_flush", {31'd0, flush_req}, 32'd0);
         check("drain_sel", {27'd0, cache_select}, 32'd0);
      end
      cache_busy = 1'b0;
      tick();                                   // -> LOOKUP
      check("drain_sel_lookup", {27'd0, cache_select}, 32'd0);
      tick();                                   // -> COMMIT (hit on latched 8'h22)
      check("drain_no_flush", {31'd0, flush_req}, 32'd0);
      tick();                                   // -> ACK
      check("drain_ack_hi", {31'd0, ctx_ack}, 32'd1);
      check("drain_sel_new", {27'd0, cache_select}, 32'd1);
      check("drain_pid", {24'd0, cur_pid}, 32'h22);
      ctx_req = 1'b0;
      tick();
      check("drain_stall_clr", {31'd0, cpu_stall}, 32'd0);
      model_sel = 5'd1;
      model_pid = 8'h22;

      // Switch to the current owner: normal hit path, select unchanged
      switch_hit(8'h22, 5'd1);

      // Wrap: 10 distinct PIDs from a clean table
      do_reset();
      for (int p = 1; p <= 10; p++) begin
         switch_miss(8'(p), 5'((p - 1) % 9), 1);
      end
      switch_hit(8'h0A, 5'd0);
      switch_miss(8'h01, 5'd1, 0);

      // Reset mid-FLUSH
      ctx_pid = 8'h33;
      ctx_req = 1'b1;
      tick();
      tick();
      tick();                                   // -> FLUSH
      check("mid_flush_req", {31'd0, flush_req}, 32'd1);
      check("mid_flush_idx", {27'd0, flush_idx}, 32'd2);
      reset   = 1'b1;
      ctx_req = 1'b0;
      tick();
      check("mid_rst_flush", {31'd0, flush_req}, 32'd0);
      check("mid_rst_sel", {27'd0, cache_select}, 32'd6);
      check("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
      check("mid_rst_pid", {24'd0, cur_pid}, 32'd0);
      reset = 1'b0;
      model_sel = 5'd6;
      model_pid = 8'h00;
      // Table invalidated and rr_ptr back to 0: 8'h0A (was in slot 0) must now miss
      switch_miss(8'h21, 5'd0, 2);
      switch_miss(8'h0A, 5'd1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
